transpose_stream_ctrl: RTL

- Streaming sequencer for the single-word circulant transpose memory.
- Accepts one MATRIX_DIM x MATRIX_DIM matrix as row-major words on a valid/ready input stream, then reads it back column-major as transposed words on a valid/ready output stream.
- Sits between the upstream producer and one circulant memory instance and owns all of that memory's write/read port sequencing.
- Single buffer: fill and drain phases do not overlap.

---
 rtl/transpose_pkg.sv | 31 +++
 rtl/transpose_out_skid.sv | 81 ++++++++
 rtl/transpose_stream_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/transpose_pkg.sv
// Shared types, derived-size helpers and parameter legality checks for the
// streaming transpose controller.
package transpose_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  function automatic int calc_cpw(input int word_len, input int col_width);
    return word_len / col_width;
  endfunction

  function automatic int calc_wpr(input int matrix_dim, input int word_len, input int col_width);
    return matrix_dim / calc_cpw(word_len, col_width);
  endfunction

  function automatic int calc_total(input int matrix_dim, input int word_len, input int col_width);
    return matrix_dim * calc_wpr(matrix_dim, word_len, col_width);
  endfunction

  // Square power-of-2 matrix, whole elements per word, and a word no wider than a row.
  function automatic bit params_legal(input int matrix_dim, input int word_len, input int col_width);
    if (matrix_dim < 2 || col_width < 1 || word_len < col_width) return 1'b0;
    if ((matrix_dim & (matrix_dim - 1)) != 0) return 1'b0;
    if ((word_len % col_width) != 0) return 1'b0;
    return calc_cpw(word_len, col_width) <= matrix_dim;
  endfunction

endpackage

// File: rtl/transpose_out_skid.sv
// Two-entry registered output buffer; credit_ok gates read issue so that
// reads in flight plus held entries can never exceed the two slots.
module transpose_out_skid
  import transpose_pkg::*;
#(
  parameter int WORD_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue,
  input  logic                push,
  input  logic [WORD_LEN-1:0] push_data,
  input  logic                push_last,
  output logic                pop_valid,
  input  logic                pop_ready,
  output logic [WORD_LEN-1:0] pop_data,
  output logic                pop_last,
  output logic                credit_ok
);

  logic [1:0]          credit_reg, credit_next;
  logic                v0_reg, v1_reg, l0_reg, l1_reg;
  logic                v0_next, v1_next, l0_next, l1_next;
  logic [WORD_LEN-1:0] d0_reg, d1_reg, d0_next, d1_next;
  logic                pop;

  assign pop       = v0_reg & pop_ready;
  assign pop_valid = v0_reg;
  assign pop_data  = d0_reg;
  assign pop_last  = v0_reg & l0_reg;
  // A slot freed by this cycle's pop may be reused at once, giving 1 word/cycle.
  assign credit_ok = (credit_reg < 2'd2) || pop;
  assign credit_next = credit_reg + {1'b0, issue} - {1'b0, pop};

  always_comb begin
    v0_next = v0_reg;
    v1_next = v1_reg;
    l0_next = l0_reg;
    l1_next = l1_reg;
    d0_next = d0_reg;
    d1_next = d1_reg;
    if (pop) begin
      v0_next = v1_reg;
      d0_next = d1_reg;
      l0_next = l1_reg;
      v1_next = 1'b0;
    end
    if (push) begin
      if (!v0_next) begin
        v0_next = 1'b1;
        d0_next = push_data;
        l0_next = push_last;
      end else begin
        v1_next = 1'b1;
        d1_next = push_data;
        l1_next = push_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit_reg <= '0;
      v0_reg     <= 1'b0;
      v1_reg     <= 1'b0;
      l0_reg     <= 1'b0;
      l1_reg     <= 1'b0;
      d0_reg     <= '0;
      d1_reg     <= '0;
    end else begin
      credit_reg <= credit_next;
      v0_reg     <= v0_next;
      v1_reg     <= v1_next;
      l0_reg     <= l0_next;
      l1_reg     <= l1_next;
      d0_reg     <= d0_next;
      d1_reg     <= d1_next;
    end
  end

endmodule

// File: rtl/transpose_stream_ctrl.sv
// Fill/drain sequencer for one circulant transpose memory. Optional performance
// counters are built when TRANSPOSE_STREAM_CTRL_PERF_EN is defined.
module transpose_stream_ctrl
  import transpose_pkg::*;
#(
  parameter int MATRIX_DIM = 4,
  parameter int COL_WIDTH  = 8,
  parameter int WORD_LEN   = 32,
  parameter int ADDR_LEN   = $clog2(MATRIX_DIM),
  parameter int MEM_RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WORD_LEN-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [WORD_LEN-1:0] m_data,
  output logic                m_valid,
  output logic                m_last,
  input  logic                m_ready,
  output logic                busy,
  output logic                mem_write_en,
  output logic [ADDR_LEN-1:0] mem_write_row,
  output logic [ADDR_LEN-1:0] mem_write_col,
  output logic [WORD_LEN-1:0] mem_data_in,
  output logic                mem_read_en,
  output logic [ADDR_LEN-1:0] mem_read_row,
  output logic [ADDR_LEN-1:0] mem_read_col,
  input  logic [WORD_LEN-1:0] mem_data_out
`ifdef TRANSPOSE_STREAM_CTRL_PERF_EN
  ,
  output logic [31:0]         perf_mat_count,
  output logic [31:0]         perf_stall_cycles
`endif
);

  localparam int CPW   = calc_cpw(WORD_LEN, COL_WIDTH);
  localparam int WPR   = calc_wpr(MATRIX_DIM, WORD_LEN, COL_WIDTH);
  localparam int TOTAL = calc_total(MATRIX_DIM, WORD_LEN, COL_WIDTH);
  localparam int CNT_W = $clog2(TOTAL) + 1;
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] WPR_C   = CNT_W'(WPR);
  localparam logic [CNT_W-1:0] CPW_C   = CNT_W'(CPW);

  if (!params_legal(MATRIX_DIM, WORD_LEN, COL_WIDTH)) begin : g_bad_params
    $error("transpose_stream_ctrl: illegal MATRIX_DIM / COL_WIDTH / WORD_LEN combination");
  end

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                s_ready_reg;
  logic                accept, read_en, credit_ok;
  logic [ADDR_LEN-1:0] major_idx, minor_idx;
  logic [MEM_RD_LAT-1:0] rd_vld_pipe, rd_last_pipe;

  // One word counter serves both phases: writes during FILL, reads during DRAIN.
  assign major_idx = ADDR_LEN'(cnt_reg / WPR_C);
  assign minor_idx = ADDR_LEN'((cnt_reg % WPR_C) * CPW_C);

  assign accept        = s_valid & s_ready_reg;
  assign s_ready       = s_ready_reg;
  assign busy          = (state_reg != IDLE);
  assign mem_write_en  = accept;
  assign mem_write_row = accept ? major_idx : '0;
  assign mem_write_col = accept ? minor_idx : '0;
  assign mem_data_in   = accept ? s_data : '0;
  assign mem_read_en   = read_en;
  assign mem_read_row  = read_en ? minor_idx : '0;
  assign mem_read_col  = read_en ? major_idx : '0;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    read_en    = 1'b0;
    case (state_reg)
      IDLE, FILL: begin
        if (accept) begin
          if (cnt_reg == LAST_C) begin
            state_next = DRAIN;
            cnt_next   = '0;
          end else begin
            state_next = FILL;
            cnt_next   = cnt_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        read_en = credit_ok && (cnt_reg != TOTAL_C);
        if (read_en) cnt_next = cnt_reg + 1'b1;
        if (m_valid && m_ready && m_last) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      s_ready_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      s_ready_reg <= (state_next != DRAIN);
    end
  end

  // Tracks which memory cycles carry valid read data; cleared on reset so late data is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_pipe  <= '0;
      rd_last_pipe <= '0;
    end else begin
      rd_vld_pipe[0]  <= read_en;
      rd_last_pipe[0] <= read_en && (cnt_reg == LAST_C);
      for (int i = 1; i < MEM_RD_LAT; i++) begin
        rd_vld_pipe[i]  <= rd_vld_pipe[i-1];
        rd_last_pipe[i] <= rd_last_pipe[i-1];
      end
    end
  end

  transpose_out_skid #(
    .WORD_LEN (WORD_LEN)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (read_en),
    .push      (rd_vld_pipe[MEM_RD_LAT-1]),
    .push_data (mem_data_out),
    .push_last (rd_last_pipe[MEM_RD_LAT-1]),
    .pop_valid (m_valid),
    .pop_ready (m_ready),
    .pop_data  (m_data),
    .pop_last  (m_last),
    .credit_ok (credit_ok)
  );

`ifdef TRANSPOSE_STREAM_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_mat_count    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (m_valid && m_ready && m_last && (perf_mat_count != '1))
        perf_mat_count <= perf_mat_count + 32'd1;
      if (m_valid && !m_ready && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
